// File: rtl/banked_memory_responder.sv
// Multi-bank SRAM responder: per-bank round-robin grant, fixed READ_LAT completion pipeline.
// Optional MEM_RESP_ERR_EN: out-of-range upper address bits complete with m_err instead of aliasing.
module banked_memory_responder #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 256,
  parameter int READ_LAT   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_BANKS-1:0]                  m_req,
  input  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_BANKS-1:0]                  m_wr,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  m_wdata,
  output logic [NUM_BANKS-1:0]                  m_gnt,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  m_rdata,
  output logic [NUM_BANKS-1:0]                  m_rdy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic [NUM_BANKS-1:0]                  m_err
`endif
);

  localparam int B = $clog2(NUM_BANKS);
  localparam int W = $clog2(BANK_DEPTH);
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef logic [B-1:0] bank_t;
  typedef logic [W-1:0] word_t;

  bank_t                              port_bank [NUM_BANKS];
  word_t                              port_word [NUM_BANKS];
  logic [NUM_BANKS-1:0]               port_err;

  bank_t                              rr_ptr_reg [NUM_BANKS];
  bank_t                              bank_sel [NUM_BANKS];
  logic [NUM_BANKS-1:0]               bank_acc;
  logic [NUM_BANKS-1:0]               bank_we;
  logic [NUM_BANKS-1:0]               bank_re;
  word_t                              bank_word [NUM_BANKS];
  logic [DATA_WIDTH-1:0]              bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0]              bank_rdata [NUM_BANKS];

  logic [NUM_BANKS-1:0]               s1_valid_reg, s1_rd_reg, s1_err_reg;
  bank_t                              s1_bank_reg [NUM_BANKS];
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] s1_data;

  logic [NUM_BANKS-1:0]               out_valid, out_err;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] out_data, resp_data, rdata_hold_reg;

  // Address decode; the error flag stays constant-zero when the feature is disabled.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_decode
    assign port_bank[gi] = m_addr[gi][B-1:0];
    assign port_word[gi] = m_addr[gi][B+W-1:B];
    assign port_err[gi]  = ERR_EN & ((m_addr[gi] >> (B + W)) != '0);
  end

  // Each bank scans ports starting at its pointer; first hit wins.
  always_comb begin
    bank_t cand;
    cand     = '0;
    m_gnt    = '0;
    bank_acc = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        cand = bank_t'(rr_ptr_reg[b] + bank_t'(i));
        if (rst_n && !bank_acc[b] && m_req[cand] && port_bank[cand] == bank_t'(b)) begin
          bank_acc[b]  = 1'b1;
          bank_sel[b]  = cand;
          m_gnt[cand]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_word[b]  = port_word[bank_sel[b]];
      bank_wdata[b] = m_wdata[bank_sel[b]];
      bank_we[b]    = bank_acc[b] & m_wr[bank_sel[b]] & ~port_err[bank_sel[b]];
      bank_re[b]    = bank_acc[b] & ~m_wr[bank_sel[b]] & ~port_err[bank_sel[b]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_reg[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (bank_acc[b]) rr_ptr_reg[b] <= bank_t'(bank_sel[b] + 1'b1);
    end
  end

  // Single-port banks; contents intentionally survive reset.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;
    always_ff @(posedge clk) begin
      if (bank_we[gi]) mem[bank_word[gi]] <= bank_wdata[gi];
      if (bank_re[gi]) rdata_reg <= mem[bank_word[gi]];
    end
    assign bank_rdata[gi] = rdata_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= '0;
      s1_rd_reg    <= '0;
      s1_err_reg   <= '0;
      for (int p = 0; p < NUM_BANKS; p++) s1_bank_reg[p] <= '0;
    end else begin
      s1_valid_reg <= m_gnt;
      s1_rd_reg    <= ~m_wr;
      s1_err_reg   <= port_err;
      for (int p = 0; p < NUM_BANKS; p++) s1_bank_reg[p] <= port_bank[p];
    end
  end

  // Bank read register holds its value until the next read of that bank, so it is safe to steer here.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_s1_data
    assign s1_data[gi] = (s1_rd_reg[gi] & ~s1_err_reg[gi]) ? bank_rdata[s1_bank_reg[gi]] : '0;
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [NUM_BANKS-1:0]                 s2_valid_reg, s2_err_reg;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] s2_data_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_reg <= '0;
        s2_err_reg   <= '0;
        s2_data_reg  <= '0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        s2_err_reg   <= s1_err_reg;
        s2_data_reg  <= s1_data;
      end
    end
    assign out_valid = s2_valid_reg;
    assign out_err   = s2_err_reg;
    assign out_data  = s2_data_reg;
  end else begin : g_lat1
    assign out_valid = s1_valid_reg;
    assign out_err   = s1_err_reg;
    assign out_data  = s1_data;
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_out
    assign resp_data[gi] = out_err[gi] ? '0 : out_data[gi];
    assign m_rdata[gi]   = out_valid[gi] ? resp_data[gi] : rdata_hold_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold_reg <= '0;
    end else begin
      for (int p = 0; p < NUM_BANKS; p++)
        if (out_valid[p]) rdata_hold_reg[p] <= resp_data[p];
    end
  end

  assign m_rdy = out_valid;
`ifdef MEM_RESP_ERR_EN
  assign m_err = out_valid & out_err;
`endif

endmodule

// File: tb/tb_banked_memory_responder.sv
// Randomized bench for banked_memory_responder against a cycle-level reference model.
module tb_banked_memory_responder;
  localparam int N = 4, AW = 16, DW = 32, DEPTH = 256, LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         m_req, m_wr, m_gnt, m_rdy;
  logic [N-1:0][AW-1:0] m_addr;
  logic [N-1:0][DW-1:0] m_wdata, m_rdata;
`ifdef MEM_RESP_ERR_EN
  logic [N-1:0]         m_err;
`endif

  banked_memory_responder #(
    .NUM_BANKS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_DEPTH(DEPTH), .READ_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_wr(m_wr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rdy(m_rdy)
`ifdef MEM_RESP_ERR_EN
    , .m_err(m_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: flat word store indexed by the low 10 address bits, rr pointers, completion slots.
  logic [DW-1:0] ref_mem [1024];
  int            rr [N];
  int            cyc = 0;
  logic          exp_v [N][4];
  logic          exp_e [N][4];
  logic [DW-1:0] exp_d [N][4];
  logic [DW-1:0] last_rdata [N];
  logic [N-1:0]  obs_gnt, obs_rdy, obs_err;
  logic [DW-1:0] obs_rdata [N];

  function automatic bit addr_err(input logic [AW-1:0] a);
`ifdef MEM_RESP_ERR_EN
    return a[AW-1:10] != '0;
`else
    return (a & 16'h0000) != 16'h0000;
`endif
  endfunction

  task automatic clear_model();
    for (int p = 0; p < N; p++) begin
      rr[p] = 0;
      last_rdata[p] = '0;
      for (int s = 0; s < 4; s++) begin
        exp_v[p][s] = 1'b0;
        exp_e[p][s] = 1'b0;
        exp_d[p][s] = '0;
      end
    end
  endtask

  task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[p] = 1'b1;
    m_wr[p] = wr;
    m_addr[p] = a;
    m_wdata[p] = d;
  endtask

  // One clock cycle: predict and check grants/completions, then advance the model.
  task automatic step();
    logic [N-1:0] eg;
    int best, bd, d, slot, ns, idx;
    bit e;
    @(negedge clk);
    eg = '0;
    for (int b = 0; b < N; b++) begin
      best = -1;
      bd = N;
      for (int p = 0; p < N; p++) begin
        if (m_req[p] && int'(m_addr[p][1:0]) == b) begin
          d = (p - rr[b] + N) % N;
          if (d < bd) begin bd = d; best = p; end
        end
      end
      if (best >= 0) eg[best] = 1'b1;
    end
    obs_gnt = m_gnt;
    obs_rdy = m_rdy;
    obs_err = '0;
`ifdef MEM_RESP_ERR_EN
    obs_err = m_err;
`endif
    for (int p = 0; p < N; p++) obs_rdata[p] = m_rdata[p];
    check_value($sformatf("gnt c%0d", cyc), 64'(m_gnt), 64'(eg));
    slot = cyc % 4;
    for (int p = 0; p < N; p++) begin
      check_value($sformatf("rdy c%0d p%0d", cyc, p), 64'(m_rdy[p]), 64'(exp_v[p][slot]));
      if (exp_v[p][slot]) last_rdata[p] = exp_d[p][slot];
      check_value($sformatf("rdata c%0d p%0d", cyc, p), 64'(m_rdata[p]), 64'(last_rdata[p]));
`ifdef MEM_RESP_ERR_EN
      check_value($sformatf("err c%0d p%0d", cyc, p), 64'(m_err[p]),
                  64'(exp_v[p][slot] & exp_e[p][slot]));
`endif
      exp_v[p][slot] = 1'b0;
    end
    ns = (cyc + LAT) % 4;
    for (int p = 0; p < N; p++) begin
      if (eg[p]) begin
        e = addr_err(m_addr[p]);
        idx = int'(m_addr[p][9:0]);
        exp_v[p][ns] = 1'b1;
        exp_e[p][ns] = e;
        exp_d[p][ns] = (!m_wr[p] && !e) ? ref_mem[idx] : '0;
        $display("cyc %0d port %0d %s addr %h wdata %h", cyc, p, m_wr[p] ? "WR" : "RD",
                 m_addr[p], m_wdata[p]);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (eg[p]) begin
        if (m_wr[p] && !addr_err(m_addr[p])) ref_mem[int'(m_addr[p][9:0])] = m_wdata[p];
        rr[int'(m_addr[p][1:0])] = (p + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    m_req = m_req & ~eg;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_value("rst gnt", 64'(m_gnt), 64'h0);
    check_value("rst rdy", 64'(m_rdy), 64'h0);
    for (int p = 0; p < N; p++)
      check_value($sformatf("rst rdata p%0d", p), 64'(m_rdata[p]), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_req = '0;
    clear_model();
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] up;
    logic [7:0] wd;
    logic [1:0] bk;
    m_req = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
    clear_model();
    #2;
    for (int p = 0; p < N; p++) issue(p, 1'b1, AW'(p), 32'h0);
    do_reset();

    // Distinct-bank writes fill words 0..15 of every bank; first beat is the all-grant case.
    for (int w = 0; w < 16; w++) begin
      for (int p = 0; p < N; p++) issue(p, 1'b1, AW'((w << 2) | p), $urandom);
      step();
      if (w == 0)   check_value("t1 gnt", 64'(obs_gnt), 64'hF);
      if (w == LAT) check_value("t1 rdy", 64'(obs_rdy), 64'hF);
    end
    repeat (LAT) step();

    issue(0, 1'b1, 16'h0004, 32'hDEADBEEF);
    step();
    issue(0, 1'b0, 16'h0004, 32'h0);
    step();
    repeat (LAT) step();
    check_value("t2 rdy", 64'(obs_rdy[0]), 64'h1);
    check_value("t2 rdata", 64'(obs_rdata[0]), 64'hDEADBEEF);

    // Four ports contend for bank 1 from a freshly reset pointer.
    do_reset();
    for (int p = 0; p < N; p++) issue(p, 1'b0, AW'((p << 2) | 1), 32'h0);
    for (int i = 0; i < N; i++) begin
      step();
      check_value($sformatf("t3 gnt %0d", i), 64'(obs_gnt), 64'(1 << i));
    end
    for (int p = 0; p < N; p++) issue(p, 1'b0, AW'((p << 2) | 1), 32'h0);
    step();
    check_value("t3 wrap gnt", 64'(obs_gnt), 64'h1);
    repeat (N - 1 + LAT) step();

    // Reset with reads in flight drops them; stored data is untouched.
    issue(0, 1'b0, 16'h0004, 32'h0);
    issue(1, 1'b0, 16'h0009, 32'h0);
    step();
    do_reset();
    repeat (LAT + 1) step();
    check_value("t4 no rdy", 64'(obs_rdy), 64'h0);
    issue(0, 1'b0, 16'h0004, 32'h0);
    step();
    repeat (LAT) step();
    check_value("t4 rdata", 64'(obs_rdata[0]), 64'hDEADBEEF);

`ifdef MEM_RESP_ERR_EN
    issue(0, 1'b1, 16'h8000, 32'hA5A5A5A5);
    step();
    check_value("t5 gnt", 64'(obs_gnt[0]), 64'h1);
    repeat (LAT) step();
    check_value("t5 rdy", 64'(obs_rdy[0]), 64'h1);
    check_value("t5 err", 64'(obs_err[0]), 64'h1);
    issue(0, 1'b0, 16'h0000, 32'h0);
    step();
    repeat (LAT) step();
    check_value("t5 rdata", 64'(obs_rdata[0]), 64'(ref_mem[0]));
`else
    issue(0, 1'b1, 16'h8004, 32'h12345678);
    step();
    issue(0, 1'b0, 16'h0004, 32'h0);
    step();
    repeat (LAT) step();
    check_value("t6 alias rdata", 64'(obs_rdata[0]), 64'h12345678);
`endif

    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!m_req[p] && $urandom_range(1, 0) == 1) begin
          up = ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'h0;
          wd = 8'($urandom_range(15, 0));
          bk = 2'($urandom);
          issue(p, 1'($urandom), {up, wd, bk}, $urandom);
        end
      end
      step();
    end
    m_req = '0;
    repeat (LAT + 1) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
